register_bank_io: RTL and testbench

- Parametrised in-band register access engine: serves read/write requests from the in-band command path against a read-only status bundle plus a writable bank of settings registers.
- Successor to the fixed 8-register/44-word read-back block. Adds a registered valid/ready request-response handshake, per-byte write masks, error reporting, read-back of settings, and parametrised bank size, base address and bundle depth.
- Sits between the in-band packet parser and the per-channel control logic (RSSI thresholds, wait counters and similar).

---
 rtl/register_bank_io.sv | 195 +++++++++++++++++++
 tb/tb_register_bank_io.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_io.sv
// register_bank_io
//   In-band register access engine. Serves read/write requests from the
//   in-band command path against a read-only status bundle (addresses
//   0..RO_COUNT-1) and a bank of NUM_REGS writable settings registers
//   (addresses BASE_ADDR..BASE_ADDR+NUM_REGS-1). Each request takes an
//   IDLE -> EXEC -> RESP round trip.
//
// Ports
//   clk, reset              : system clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_write, req_addr     : operation and target address
//   req_data, req_mask      : write data and per-byte enables
//   rsp_valid/rsp_ready     : response handshake
//   rsp_data, rsp_err       : read data or post-write value, error flag
//   ro_bus                  : flattened read-only bundle, word k at [k*DATA_W +: DATA_W]
//   reg_out                 : flattened settings register contents
//   strobe_wr               : one-cycle pulse on a successful write
//   addr_wr, data_wr        : address and merged value of the last successful write
module register_bank_io #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int RO_COUNT  = 44,
  parameter int NUM_REGS  = 8,
  parameter int BASE_ADDR = 50
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_data,
  input  logic [DATA_W/8-1:0]          req_mask,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_err,
  input  logic [RO_COUNT*DATA_W-1:0]   ro_bus,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic                         strobe_wr,
  output logic [ADDR_W-1:0]            addr_wr,
  output logic [DATA_W-1:0]            data_wr
);

  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // One extra bit so BASE_ADDR+NUM_REGS == 2^ADDR_W is still representable.
  localparam logic [ADDR_W:0] SET_LO = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] SET_HI = (ADDR_W+1)'(BASE_ADDR + NUM_REGS);
  localparam logic [ADDR_W:0] RO_HI  = (ADDR_W+1)'(RO_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                wr_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   data_p0;
  logic [MASK_W-1:0]   mask_p0;

  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic [ADDR_W:0]     addr_ext_p0;
  logic [ADDR_W:0]     idx_ext_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic                set_hit_p0;
  logic                ro_hit_p0;
  logic [DATA_W-1:0]   ro_word_p0;
  logic [DATA_W-1:0]   reg_old_p0;
  logic [DATA_W-1:0]   merged_p0;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [MASK_W-1:0] be
  );
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < MASK_W; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return (old_v & ~m) | (new_v & m);
  endfunction

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- Stage p0: request capture (accepted only in IDLE) ----
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      wr_p0   <= req_write;
      addr_p0 <= req_addr;
      data_p0 <= req_data;
      mask_p0 <= req_mask;
    end
  end

  // ---- Stage p0 -> EXEC: address decode and byte merge ----
  assign addr_ext_p0 = {1'b0, addr_p0};
  assign set_hit_p0  = (addr_ext_p0 >= SET_LO) && (addr_ext_p0 < SET_HI);
  assign ro_hit_p0   = (addr_ext_p0 < RO_HI);
  assign idx_ext_p0  = addr_ext_p0 - SET_LO;
  assign idx_p0      = idx_ext_p0[IDX_W-1:0];

  always_comb begin
    ro_word_p0 = '0;
    for (int k = 0; k < RO_COUNT; k++) begin
      if (addr_ext_p0 == (ADDR_W+1)'(k)) ro_word_p0 = ro_bus[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    reg_old_p0 = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (idx_p0 == IDX_W'(r)) reg_old_p0 = regs[r];
    end
  end

  assign merged_p0 = merge_bytes(reg_old_p0, data_p0, mask_p0);

  // ---- Stage p1: register update and response ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      strobe_wr <= 1'b0;
      addr_wr   <= '0;
      data_wr   <= '0;
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      // The strobe lives exactly for the first RESP cycle.
      strobe_wr <= 1'b0;
      case (state)
        EXEC: begin
          rsp_valid <= 1'b1;
          if (wr_p0) begin
            if (set_hit_p0) begin
              regs[idx_p0] <= merged_p0;
              strobe_wr    <= 1'b1;
              addr_wr      <= addr_p0;
              data_wr      <= merged_p0;
              rsp_data     <= merged_p0;
              rsp_err      <= 1'b0;
            end else begin
              rsp_data <= '1;
              rsp_err  <= 1'b1;
            end
          end else if (ro_hit_p0) begin
            rsp_data <= ro_word_p0;
            rsp_err  <= 1'b0;
          end else if (set_hit_p0) begin
            rsp_data <= reg_old_p0;
            rsp_err  <= 1'b0;
          end else begin
            rsp_data <= '1;
            rsp_err  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_register_bank_io.sv
module tb_register_bank_io;

  localparam int DW  = 32;
  localparam int AW  = 7;
  localparam int ROC = 44;
  localparam int NR  = 8;
  localparam int BA  = 50;
  localparam int MW  = DW / 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [AW-1:0]        req_addr;
  logic [DW-1:0]        req_data;
  logic [MW-1:0]        req_mask;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_err;
  logic [ROC*DW-1:0]    ro_bus;
  logic [NR*DW-1:0]     reg_out;
  logic                 strobe_wr;
  logic [AW-1:0]        addr_wr;
  logic [DW-1:0]        data_wr;

  register_bank_io #(
    .DATA_W(DW), .ADDR_W(AW), .RO_COUNT(ROC), .NUM_REGS(NR), .BASE_ADDR(BA)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ro_bus(ro_bus), .reg_out(reg_out),
    .strobe_wr(strobe_wr), .addr_wr(addr_wr), .data_wr(data_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    data;
    logic             err;
    logic [NR*DW-1:0] regs;
  } rsp_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } stb_exp_t;

  rsp_exp_t rq[$];
  stb_exp_t sq[$];

  logic [DW-1:0] model_regs [NR];
  logic [DW-1:0] ro_model   [ROC];

  int  checks = 0;
  int  errors = 0;
  logic rand_mode = 1'b0;
  logic prev_strobe = 1'b0;
  rsp_exp_t mon_e;
  stb_exp_t mon_s;

  always_comb begin
    ro_bus = '0;
    for (int k = 0; k < ROC; k++) ro_bus[k*DW +: DW] = ro_model[k];
  end

  task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] flat_regs();
    logic [NR*DW-1:0] f;
    for (int r = 0; r < NR; r++) f[r*DW +: DW] = model_regs[r];
    return f;
  endfunction

  // Reference model: decides the response purely from the address map.
  task automatic predict(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m);
    rsp_exp_t e;
    stb_exp_t s;
    logic [DW-1:0] v;
    int ai;
    ai = int'(a);
    e.data = '1;
    e.err  = 1'b1;
    if (w) begin
      if (ai >= BA && ai < BA + NR) begin
        v = model_regs[ai - BA];
        for (int b = 0; b < MW; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
        model_regs[ai - BA] = v;
        e.data = v;
        e.err  = 1'b0;
        s.addr = a;
        s.data = v;
        sq.push_back(s);
      end
    end else if (ai < ROC) begin
      e.data = ro_model[ai];
      e.err  = 1'b0;
    end else if (ai >= BA && ai < BA + NR) begin
      e.data = model_regs[ai - BA];
      e.err  = 1'b0;
    end
    e.regs = flat_regs();
    rq.push_back(e);
  endtask

  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 200) begin
      if (rand_mode) rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    if (rand_mode) begin
      rsp_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ro_model[$urandom_range(0, ROC-1)] = $urandom();
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    req_mask  = m;
    predict(w, a, d, m);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = $urandom();
    req_addr  = AW'($urandom());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || rsp_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %h err %0d expected no response", rsp_data, rsp_err);
      end else begin
        mon_e = rq.pop_front();
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_err", rsp_err, mon_e.err);
        chk("reg_out", reg_out, mon_e.regs);
      end
    end
  end

  // Write strobe monitor
  always @(negedge clk) begin
    if (strobe_wr) begin
      if (prev_strobe) begin
        checks++;
        errors++;
        $display("FAIL strobe_width: got 2+ cycles expected 1");
      end else if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got addr %0d data %h expected none", addr_wr, data_wr);
      end else begin
        mon_s = sq.pop_front();
        chk("addr_wr", addr_wr, mon_s.addr);
        chk("data_wr", data_wr, mon_s.data);
      end
    end
    prev_strobe = strobe_wr;
  end

  logic [DW-1:0] hold_v;
  int n;

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_mask  = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < ROC; k++) ro_model[k] = '0;
    for (int r = 0; r < NR; r++) model_regs[r] = '0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_reg_out", reg_out, '0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_strobe", strobe_wr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_addr_wr", addr_wr, 0);
    chk("rst_data_wr", data_wr, 0);

    // Directed: full write, read-back, partial byte write
    do_req(1'b1, 7'd51, 32'h12345678, 4'hF);
    do_req(1'b0, 7'd51, 32'h0, 4'h0);
    do_req(1'b1, 7'd51, 32'hAABBCCDD, 4'b0101);
    do_req(1'b0, 7'd51, 32'h0, 4'h0);
    // Read-only bundle, error addresses, write to read-only space
    ro_model[2] = 32'h00000ABC;
    ro_model[3] = 32'h0BADF00D;
    do_req(1'b0, 7'd2, 32'h0, 4'h0);
    do_req(1'b0, 7'd45, 32'h0, 4'h0);
    do_req(1'b1, 7'd2, 32'hCAFEBABE, 4'hF);
    do_req(1'b1, 7'd57, 32'h87654321, 4'h0);
    do_req(1'b0, 7'd127, 32'h0, 4'h0);
    drain();

    // Back-pressure: response must hold while rsp_ready is low
    rsp_ready = 1'b0;
    do_req(1'b0, 7'd3, 32'h0, 4'h0);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    hold_v = rsp_data;
    chk("hold_first_data", hold_v, 32'h0BADF00D);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'd50;
    req_data  = 32'h55555555;
    req_mask  = 4'hF;
    ro_model[3] = 32'hFFFF0000;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, hold_v);
      chk("hold_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_req_ready", req_ready, 1);
    chk("release_rsp_valid", rsp_valid, 0);
    do_req(1'b0, 7'd50, 32'h0, 4'h0);
    do_req(1'b0, 7'd3, 32'h0, 4'h0);
    drain();

    // Randomised traffic with random back-pressure
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      case ($urandom_range(0, 2))
        0:       a = AW'($urandom_range(0, ROC-1));
        1:       a = AW'($urandom_range(BA, BA+NR-1));
        default: a = AW'($urandom_range(0, (1 << AW) - 1));
      endcase
      do_req(1'($urandom_range(0, 1)), a, $urandom(), MW'($urandom()));
    end
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Reset asserted during the EXEC cycle of a write
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'd50;
    req_data  = 32'hDEADBEEF;
    req_mask  = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < NR; r++) model_regs[r] = '0;
    chk("rst_exec_strobe", strobe_wr, 0);
    chk("rst_exec_rsp_valid", rsp_valid, 0);
    chk("rst_exec_req_ready", req_ready, 1);
    chk("rst_exec_reg_out", reg_out, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    do_req(1'b0, 7'd50, 32'h0, 4'h0);
    do_req(1'b1, 7'd50, 32'h01020304, 4'b1000);
    drain();

    repeat (3) @(posedge clk);
    chk("pending_rsp", rq.size(), 0);
    chk("pending_strobe", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
